// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes for hazards, memory waits and debug halt.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined; otherwise the ports read 0.
module pipe_ctrl #(
    parameter int unsigned REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_uses_rs,
    input  logic            id_uses_rt,
    input  logic [REGW-1:0] ex_rd,
    input  logic            ex_mem_read,
    input  logic            ex_branch_taken,
    input  logic            mem_req,
    input  logic            mem_ready,
    input  logic            dbg_halt,
    input  logic            dbg_step,
    output logic            pc_en,
    output logic            if_id_en,
    output logic            id_ex_en,
    output logic            ex_mem_en,
    output logic            mem_wb_en,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic [1:0]      state,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_count
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StHalt    = 2'd2,
        StStep    = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   step_pending_q, step_pending_d;

    logic       mem_stall;
    logic       load_use;
    logic       advance;
    logic [4:0] en_vec;    // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [1:0] flush_vec; // {if_id, id_ex}

    assign mem_stall = mem_req && !mem_ready;
    assign load_use  = ex_mem_read && (ex_rd != '0) &&
                       ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

    always_comb begin
        state_d        = state_q;
        step_pending_d = step_pending_q;
        advance        = 1'b0;
        en_vec         = 5'b00000;
        flush_vec      = 2'b00;

        unique case (state_q)
            StRun: begin
                if (mem_stall) begin
                    state_d = StMemWait;
                end else if (dbg_halt) begin
                    state_d = StHalt;
                end else begin
                    advance = 1'b1;
                end
            end
            StMemWait: begin
                if (mem_ready) begin
                    advance        = 1'b1;
                    state_d        = step_pending_q ? StHalt : StRun;
                    step_pending_d = 1'b0;
                end
            end
            StHalt: begin
                if (!dbg_halt) begin
                    state_d = StRun;
                end else if (dbg_step) begin
                    state_d = StStep;
                end
            end
            StStep: begin
                if (mem_stall) begin
                    step_pending_d = 1'b1;
                    state_d        = StMemWait;
                end else begin
                    advance = 1'b1;
                    state_d = StHalt;
                end
            end
            default: state_d = StRun;
        endcase

        // A taken branch kills the ID instruction, so it masks any load-use hazard.
        if (advance) begin
            if (ex_branch_taken) begin
                en_vec    = 5'b11111;
                flush_vec = 2'b11;
            end else if (load_use) begin
                en_vec    = 5'b00111;
                flush_vec = 2'b01;
            end else begin
                en_vec = 5'b11111;
            end
        end

        if (rst) begin
            en_vec    = 5'b00000;
            flush_vec = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StRun;
            step_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_pending_q <= step_pending_d;
        end
    end

    assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = en_vec;
    assign {if_id_flush, id_ex_flush}                        = flush_vec;
    assign state                                             = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q, flush_count_q;
    logic        branch_fire;

    assign branch_fire = advance && ex_branch_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!pc_en && (state_q != StHalt)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (branch_fire) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push expected outputs, a monitor pops and checks.
// Counter expectations apply when PIPE_CTRL_PERF_EN is defined; otherwise counters must read 0.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    localparam logic [4:0] ALL  = 5'b11111;
    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] LU   = 5'b00111;
    localparam logic [1:0] F0   = 2'b00;
    localparam logic [1:0] FB   = 2'b11;
    localparam logic [1:0] FL   = 2'b01;
    localparam logic [1:0] SRun = 2'd0;
    localparam logic [1:0] SMw  = 2'd1;
    localparam logic [1:0] SHlt = 2'd2;
    localparam logic [1:0] SStp = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken;
    logic        mem_req, mem_ready, dbg_halt, dbg_step;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush;
    logic [1:0]  state;
    logic [31:0] stall_cycles, flush_count;

    typedef struct packed {
        logic [4:0]  en;
        logic [1:0]  fl;
        logic [1:0]  st;
        logic        chk;
        logic [31:0] stall;
        logic [31:0] flc;
    } exp_t;

    exp_t sb[$];
    int   nchk  = 0;
    int   nfail = 0;
    int   vec   = 0;

    pipe_ctrl #(.REGW(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .dbg_halt        (dbg_halt),
        .dbg_step        (dbg_step),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .state           (state),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    // Monitor: outputs are combinational, so every cycle presents a response at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                nchk++;
                if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} !== e.en) begin
                    nfail++;
                    $display("FAIL en vec%0d: got %b want %b", vec,
                             {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, e.en);
                end
                nchk++;
                if ({if_id_flush, id_ex_flush} !== e.fl) begin
                    nfail++;
                    $display("FAIL flush vec%0d: got %b want %b", vec,
                             {if_id_flush, id_ex_flush}, e.fl);
                end
                nchk++;
                if (state !== e.st) begin
                    nfail++;
                    $display("FAIL state vec%0d: got %0d want %0d", vec, state, e.st);
                end
                if (e.chk) begin
                    nchk++;
                    if (stall_cycles !== e.stall) begin
                        nfail++;
                        $display("FAIL stall_cycles vec%0d: got %0d want %0d", vec,
                                 stall_cycles, e.stall);
                    end
                    nchk++;
                    if (flush_count !== e.flc) begin
                        nfail++;
                        $display("FAIL flush_count vec%0d: got %0d want %0d", vec,
                                 flush_count, e.flc);
                    end
                end
                vec++;
            end
        end
    end

    task automatic clr();
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0; ex_branch_taken = 0;
        mem_req = 0; mem_ready = 0; dbg_halt = 0; dbg_step = 0;
    endtask

    task automatic lu_stim(input logic [4:0] r);
        ex_mem_read = 1; ex_rd = r; id_rs = r; id_uses_rs = 1;
    endtask

    task automatic c(input logic [4:0] en, input logic [1:0] fl, input logic [1:0] st);
        sb.push_back('{en: en, fl: fl, st: st, chk: 1'b0, stall: 32'd0, flc: 32'd0});
        @(posedge clk);
        #1;
    endtask

    task automatic k(input logic [4:0] en, input logic [1:0] fl, input logic [1:0] st,
                     input int unsigned s, input int unsigned f);
        sb.push_back('{en: en, fl: fl, st: st, chk: 1'b1,
                       stall: Perf ? s : 32'd0, flc: Perf ? f : 32'd0});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        @(posedge clk);
        #1;

        // Reset and first RUN cycle
        k(NONE, F0, SRun, 0, 0);
        rst = 1'b0;
        k(ALL, F0, SRun, 0, 0);

        // Load-use on rs, then ex_rd==0, uses_rs==0, rt variant, non-load
        lu_stim(5'd8);
        c(LU, FL, SRun);
        clr();
        k(ALL, F0, SRun, 1, 0);
        ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
        c(ALL, F0, SRun);
        clr();
        ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 0;
        c(ALL, F0, SRun);
        clr();
        ex_mem_read = 1; ex_rd = 5; id_rt = 5; id_uses_rt = 1;
        c(LU, FL, SRun);
        ex_mem_read = 0;
        c(ALL, F0, SRun);
        clr();
        k(ALL, F0, SRun, 2, 0);

        // Branch masks a simultaneous load-use
        lu_stim(5'd8);
        ex_branch_taken = 1;
        c(ALL, FB, SRun);
        clr();
        k(ALL, F0, SRun, 2, 1);

        // dbg_step outside HALT has no effect
        dbg_step = 1;
        c(ALL, F0, SRun);
        clr();

        // Memory wait: ready on the 4th cycle
        mem_req = 1;
        c(NONE, F0, SRun);
        c(NONE, F0, SMw);
        c(NONE, F0, SMw);
        mem_ready = 1;
        k(ALL, F0, SMw, 5, 1);
        clr();
        k(ALL, F0, SRun, 5, 1);
        mem_req = 1; mem_ready = 1;
        c(ALL, F0, SRun);
        clr();
        k(ALL, F0, SRun, 5, 1);

        // Stall beats halt; halt ignored in MEM_WAIT; branch on the ready cycle
        mem_req = 1; dbg_halt = 1;
        c(NONE, F0, SRun);
        dbg_halt = 0;
        c(NONE, F0, SMw);
        mem_ready = 1; ex_branch_taken = 1; dbg_halt = 1;
        k(ALL, FB, SMw, 7, 1);
        clr();
        dbg_halt = 1;
        c(NONE, F0, SRun);
        dbg_halt = 0;
        c(NONE, F0, SHlt);
        k(ALL, F0, SRun, 8, 2);

        // Reset mid-MEM_WAIT
        mem_req = 1;
        c(NONE, F0, SRun);
        c(NONE, F0, SMw);
        rst = 1;
        k(NONE, F0, SRun, 0, 0);
        rst = 0;
        clr();
        k(ALL, F0, SRun, 0, 0);

        // Halt held for 5 cycles then released
        dbg_halt = 1;
        c(NONE, F0, SRun);
        for (int i = 0; i < 4; i++) k(NONE, F0, SHlt, 1, 0);
        dbg_halt = 0;
        k(NONE, F0, SHlt, 1, 0);
        k(ALL, F0, SRun, 1, 0);

        // Single step through a memory wait, then a plain step with load-use
        dbg_halt = 1;
        c(NONE, F0, SRun);
        dbg_step = 1;
        c(NONE, F0, SHlt);
        dbg_step = 0; mem_req = 1;
        c(NONE, F0, SStp);
        c(NONE, F0, SMw);
        mem_ready = 1;
        c(ALL, F0, SMw);
        mem_req = 0; mem_ready = 0;
        k(NONE, F0, SHlt, 4, 0);
        dbg_step = 1;
        c(NONE, F0, SHlt);
        lu_stim(5'd3);
        c(LU, FL, SStp);
        clr();
        dbg_halt = 1;
        k(NONE, F0, SHlt, 5, 0);
        dbg_halt = 0;
        c(NONE, F0, SHlt);
        k(ALL, F0, SRun, 5, 0);

        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            nfail++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central sequencing controller for the 5-stage pipeline. Drives the enable and bubble-flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Resolves load-use hazards, taken-branch redirects, multi-cycle data-memory waits and debug halt/single-step. Sits beside the datapath in the CPU top level; all pipeline registers take their `en` from this block.

## Interface
Parameters:
- `REGW`, 5, register-specifier width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_rs`, `id_rt` in REGW: source registers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt` in 1: ID instruction reads rs/rt.
- `ex_rd` in REGW: destination register of the instruction in EX.
- `ex_mem_read` in 1: EX instruction is a load.
- `ex_branch_taken` in 1: EX resolved a taken branch or jump.
- `mem_req` in 1: MEM stage is issuing a data access this cycle.
- `mem_ready` in 1: data memory completes the access this cycle.
- `dbg_halt` in 1: debug halt request (level).
- `dbg_step` in 1: single-step request (pulse, honoured only in HALT).
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en` out 1: stage register capture enables.
- `if_id_flush`, `id_ex_flush` out 1: load a bubble on the next edge; valid only together with the matching `_en`.
- `state` out 2: FSM state.
- `stall_cycles` out 32: stall counter.
- `flush_count` out 32: branch-flush counter.

## Operation
FSM states: RUN=0, MEM_WAIT=1, HALT=2, STEP=3. There is also an internal `step_pending` flag.

Advance rules apply in RUN, in STEP, and in MEM_WAIT on the cycle `mem_ready`=1. They are evaluated in this priority order:
1. Memory stall: `mem_req`=1 and `mem_ready`=0.
   - All five enables 0.
   - Next state MEM_WAIT.
   - Not applicable in MEM_WAIT.
2. Branch: `ex_branch_taken`=1.
   - All enables 1.
   - `if_id_flush`=1 and `id_ex_flush`=1.
   - A load-use hazard in the same cycle is ignored, because the ID instruction is killed.
3. Load-use: `ex_mem_read`=1, `ex_rd`≠0, and either (`id_uses_rs` and `id_rs`==`ex_rd`) or (`id_uses_rt` and `id_rt`==`ex_rd`).
   - `pc_en`=0, `if_id_en`=0.
   - `id_ex_en`=1 with `id_ex_flush`=1.
   - `ex_mem_en`=1, `mem_wb_en`=1.
4. Otherwise: all enables 1, all flushes 0.

Transitions:
- RUN:
  - If rule 1 applies, go to MEM_WAIT.
  - Else if `dbg_halt`=1: all enables 0 and flushes 0 (the halt wins over rules 2–4), go to HALT.
  - Else stay in RUN.
- MEM_WAIT:
  - While `mem_ready`=0: all enables 0.
  - On `mem_ready`=1: apply rules 2–4. Go to HALT if `step_pending`, else RUN. `step_pending` clears.
- HALT:
  - All enables 0.
  - `dbg_halt`=0 → RUN.
  - Else `dbg_step`=1 → STEP.
- STEP:
  - Apply the advance rules once.
  - If rule 1 applies, set `step_pending` and go to MEM_WAIT.
  - Else go to HALT.
  - `dbg_step` is ignored outside HALT.

Flush outputs are 0 in every cycle not named above.

## Timing
- Outputs are combinational from the registered `state`/`step_pending` and the current inputs. Zero-cycle latency: hazards are resolved in the same cycle they appear.
- Reset:
  - While `rst`=1: all enables 0, all flushes 0.
  - `state`=RUN, `step_pending`=0, counters 0.
  - The first cycle after deassertion evaluates as RUN.
- A MEM_WAIT stall lasts exactly N cycles when `mem_ready` rises N cycles after `mem_req`. If `mem_ready`=1 in the same cycle as `mem_req`, there is no stall.
- `rst` during MEM_WAIT or STEP aborts immediately. No pending step survives reset.
- `dbg_halt` dropping during MEM_WAIT has no effect until the wait ends.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cycles` increments on every cycle with `pc_en`=0 and `state`≠HALT and `rst`=0.
  - `flush_count` increments on every cycle where rule 2 fires.
  - Both wrap from 0xFFFFFFFF to 0.
- Macro undefined: both ports are tied to 0 and no counter flops are built. The port list is unchanged.

## Test plan
- Reset mid-MEM_WAIT: `mem_req`=1, `mem_ready`=0 for 2 cycles, then `rst` pulse → `state`=0, all enables 0 while `rst`=1, RUN enables all 1 afterwards.
- Load-use: `ex_mem_read`=1, `ex_rd`=8, `id_rs`=8, `id_uses_rs`=1 → `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1 for 1 cycle. Same stimulus with `ex_rd`=0 → no stall.
- Branch plus load-use in the same cycle → all enables 1, `if_id_flush`=`id_ex_flush`=1, `flush_count` +1.
- Memory wait: `mem_req`=1, `mem_ready` high on the 4th cycle → 3 cycles all enables 0 in MEM_WAIT, then advance. `stall_cycles`=3 (with `PIPE_CTRL_PERF_EN`).
- Single step with a memory wait: HALT, `dbg_step` pulse, `mem_req`=1/`mem_ready`=0 for 2 cycles → STEP→MEM_WAIT→(ready)→HALT, with exactly one advance cycle.
- Halt release: `dbg_halt`=1 for 5 cycles, then 0 → enables 0 throughout HALT, RUN on the next cycle, `stall_cycles` unchanged during HALT.
